// File: rtl/pwm_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pwm_ctrl_pkg
// Shared definitions for the PWM step sequencer:
//   - state_e  : sequencer FSM state encoding (IDLE/LOAD/RUN/DONE)
//   - SEL_W_DEFAULT : default width of the pwm_generation selection field
//   - HOLD_MIN : smallest effective hold count; a programmed hold of 0 is
//                stretched to this value so every step gets at least one
//                RUN cycle
// -----------------------------------------------------------------------------
package pwm_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam int SEL_W_DEFAULT = 2;
  localparam int HOLD_MIN      = 1;

endpackage : pwm_ctrl_pkg

// File: rtl/pwm_step_table.sv
// -----------------------------------------------------------------------------
// pwm_step_table
// NUM_STEPS-entry register file holding {selection, hold} per sequencer step.
//
// Ports:
//   clk_in       : clock, rising edge
//   reset_in     : synchronous active-high reset; every entry -> sel=0, hold=1
//   busy_in      : sequencer busy; writes are dropped while high
//   we_in        : write strobe
//   wr_addr_in   : entry to write
//   wr_sel_in    : selection value to store
//   wr_hold_in   : hold count to store
//   rd_addr_in   : entry to read (combinational)
//   rd_sel_out   : selection of the addressed entry
//   rd_hold_out  : hold count of the addressed entry
//
// A write accepted in the same cycle as a read of the same entry is forwarded
// to the read port, so a step loaded on that edge sees the new contents.
// -----------------------------------------------------------------------------
module pwm_step_table
  import pwm_ctrl_pkg::*;
#(
  parameter int NUM_STEPS = 4,
  parameter int HOLD_W    = 8,
  parameter int SEL_W     = SEL_W_DEFAULT,
  localparam int ADDR_W   = $clog2(NUM_STEPS)
) (
  input  logic              clk_in,
  input  logic              reset_in,
  input  logic              busy_in,
  input  logic              we_in,
  input  logic [ADDR_W-1:0] wr_addr_in,
  input  logic [SEL_W-1:0]  wr_sel_in,
  input  logic [HOLD_W-1:0] wr_hold_in,
  input  logic [ADDR_W-1:0] rd_addr_in,
  output logic [SEL_W-1:0]  rd_sel_out,
  output logic [HOLD_W-1:0] rd_hold_out
);

  logic [SEL_W-1:0]  sel_mem  [NUM_STEPS];
  logic [HOLD_W-1:0] hold_mem [NUM_STEPS];

  logic wr_ok;
  logic wr_hit;

  assign wr_ok  = we_in && !busy_in;
  assign wr_hit = wr_ok && (wr_addr_in == rd_addr_in);

  // NOTE: this table is reset on purpose (it is a handful of flops, not a RAM
  // macro); large memories should normally be left unreset.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      for (int i = 0; i < NUM_STEPS; i++) begin
        sel_mem[i]  <= '0;
        hold_mem[i] <= HOLD_W'(HOLD_MIN);
      end
    end else if (wr_ok) begin
      sel_mem[wr_addr_in]  <= wr_sel_in;
      hold_mem[wr_addr_in] <= wr_hold_in;
    end
  end

  assign rd_sel_out  = wr_hit ? wr_sel_in  : sel_mem[rd_addr_in];
  assign rd_hold_out = wr_hit ? wr_hold_in : hold_mem[rd_addr_in];

endmodule : pwm_step_table

// File: rtl/pwm_sequencer.sv
// -----------------------------------------------------------------------------
// pwm_sequencer
// Drives selection/refresh/enable of one pwm_generation instance from a small
// programmable step table. Each step is one LOAD cycle (refresh pulse, new
// selection) followed by max(hold,1) RUN cycles with enable high. Steps run in
// order, once or looping.
//
// Ports:
//   clk_in        : clock, rising edge
//   reset_in      : synchronous active-high reset (also clears the table)
//   start_in      : level; begins a sequence when sampled in IDLE
//   stop_in       : abort to IDLE; wins over start_in
//   loop_in       : 1 = wrap to step 0 after the last step
//   cfg_we_in     : table write strobe (ignored while busy_out=1)
//   cfg_addr_in   : table entry index
//   cfg_sel_in    : selection value for the entry
//   cfg_hold_in   : hold cycles for the entry (0 behaves as 1)
//   selection_out : to pwm_generation.selection
//   refresh_out   : one-cycle reload pulse to pwm_generation.refresh
//   enable_out    : to pwm_generation.enable
//   step_out      : current step index
//   busy_out      : high in LOAD/RUN
//   done_out      : one-cycle pulse on normal completion
//
// All outputs are registered: the next-state logic picks state_d/step_d, the
// output logic derives the next output values from state_d, and both are
// captured on the same edge so outputs always match the current state.
// -----------------------------------------------------------------------------
module pwm_sequencer
  import pwm_ctrl_pkg::*;
#(
  parameter int NUM_STEPS = 4,
  parameter int HOLD_W    = 8,
  parameter int SEL_W     = SEL_W_DEFAULT,
  localparam int STEP_W   = $clog2(NUM_STEPS)
) (
  input  logic              clk_in,
  input  logic              reset_in,
  input  logic              start_in,
  input  logic              stop_in,
  input  logic              loop_in,
  input  logic              cfg_we_in,
  input  logic [STEP_W-1:0] cfg_addr_in,
  input  logic [SEL_W-1:0]  cfg_sel_in,
  input  logic [HOLD_W-1:0] cfg_hold_in,
  output logic [SEL_W-1:0]  selection_out,
  output logic              refresh_out,
  output logic              enable_out,
  output logic [STEP_W-1:0] step_out,
  output logic              busy_out,
  output logic              done_out
);

  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_STEPS - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(HOLD_MIN);

  state_e            state_q, state_d;
  logic [STEP_W-1:0] step_d;
  logic [HOLD_W-1:0] cnt_q;
  logic [HOLD_W-1:0] hold_load;

  logic [SEL_W-1:0]  rd_sel;
  logic [HOLD_W-1:0] rd_hold;

  logic [SEL_W-1:0]  sel_d;
  logic              refresh_d;
  logic              enable_d;
  logic              busy_d;
  logic              done_d;

  // The table is read at the step about to be entered, so the selection and
  // hold count are ready on the edge that moves the FSM into LOAD.
  pwm_step_table #(
    .NUM_STEPS (NUM_STEPS),
    .HOLD_W    (HOLD_W),
    .SEL_W     (SEL_W)
  ) u_table (
    .clk_in      (clk_in),
    .reset_in    (reset_in),
    .busy_in     (busy_out),
    .we_in       (cfg_we_in),
    .wr_addr_in  (cfg_addr_in),
    .wr_sel_in   (cfg_sel_in),
    .wr_hold_in  (cfg_hold_in),
    .rd_addr_in  (step_d),
    .rd_sel_out  (rd_sel),
    .rd_hold_out (rd_hold)
  );

  // A programmed hold of 0 still gets one RUN cycle.
  assign hold_load = (rd_hold < HOLD_ONE) ? HOLD_ONE : rd_hold;

  // ---------------------------------------------------------------------------
  // State, step, counter and output registers
  // ---------------------------------------------------------------------------
  // NOTE: every flop here uses non-blocking assignment so all registers update
  // together from the values present before the edge.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q       <= IDLE;
      step_out      <= '0;
      cnt_q         <= '0;
      selection_out <= '0;
      refresh_out   <= 1'b0;
      enable_out    <= 1'b0;
      busy_out      <= 1'b0;
      done_out      <= 1'b0;
    end else begin
      state_q       <= state_d;
      step_out      <= step_d;
      selection_out <= sel_d;
      refresh_out   <= refresh_d;
      enable_out    <= enable_d;
      busy_out      <= busy_d;
      done_out      <= done_d;
      // The counter is loaded on entry to LOAD and only counts while staying
      // in RUN; it leaves RUN at 1, so it never has to wrap.
      if (state_d == LOAD) begin
        cnt_q <= hold_load;
      end else if (state_q == RUN && state_d == RUN) begin
        cnt_q <= cnt_q - HOLD_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned in an always_comb gets a default at the top so
  // no path can leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    step_d  = step_out;

    case (state_q)
      IDLE: begin
        if (start_in && !stop_in) begin
          state_d = LOAD;
          step_d  = '0;
        end
      end
      LOAD: state_d = RUN;
      RUN: begin
        if (cnt_q == HOLD_ONE) begin
          if (step_out != LAST_STEP) begin
            state_d = LOAD;
            step_d  = step_out + STEP_W'(1);
          end else if (loop_in) begin
            state_d = LOAD;
            step_d  = '0;
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Abort from any active state; this also suppresses the done pulse.
    if (stop_in && state_q != IDLE) begin
      state_d = IDLE;
    end

    if (state_d == IDLE) begin
      step_d = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Output logic: values the outputs take while in state_d
  // ---------------------------------------------------------------------------
  always_comb begin
    sel_d     = selection_out;   // selection holds outside LOAD
    refresh_d = 1'b0;
    enable_d  = 1'b0;
    busy_d    = 1'b0;
    done_d    = 1'b0;

    case (state_d)
      LOAD: begin
        sel_d     = rd_sel;
        refresh_d = 1'b1;
        busy_d    = 1'b1;
      end
      RUN: begin
        enable_d = 1'b1;
        busy_d   = 1'b1;
      end
      DONE: done_d = 1'b1;
      default: ;
    endcase
  end

endmodule : pwm_sequencer
